atan2_cordic: RTL and testbench

- Iterative CORDIC engine in vectoring mode. It is the inverse direction of the sin pipeline: it takes a signed point (x, y) in the shared Q18.8 format and returns the angle atan2(y, x) in radians, in the same Q18.8 format.
- Feeds angle recovery in the t_block datapath, alongside the sin/cos blocks.
- Interface: one transaction at a time, valid/ready handshake on both sides, clock-enable stall identical to the sin pipeline's en.

---
 rtl/atan2_cordic.sv | 208 ++++++++++++++++++++
 tb/tb_atan2_cordic.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/atan2_cordic.sv
// atan2_cordic: iterative vectoring-mode CORDIC returning atan2(y, x).
// Inputs and the output angle are signed Q18.8 (radians for the angle).
// One transaction in flight; valid/ready on both sides; en freezes all state.
// Optional feature macro: ATAN2_CORDIC_MAG_EN adds a gain-corrected magnitude
// output (mag).
module atan2_cordic #(
  parameter int unsigned ITERS = 12,  // 8..16
  parameter int unsigned ZFRAC = 16,  // 9..23
  parameter int unsigned GUARD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [26:0] x_in,
  input  logic signed [26:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [26:0] angle,
  output logic               zero
`ifdef ATAN2_CORDIC_MAG_EN
  ,
  output logic        [26:0] mag
`endif
);

  // x/y: 2 MSB guard bits absorb the CORDIC gain and negation of -2^26.
  localparam int unsigned XW = 27 + 2 + GUARD;
  // z is wide enough that the Q18.8 result slice [ZFRAC+18:ZFRAC-8] exists.
  localparam int unsigned ZW = ZFRAC + 19;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StPrerot = 3'd1;
  localparam logic [2:0] StIter   = 3'd2;
  localparam logic [2:0] StRound  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // Round a Q24 angle constant to ZFRAC fractional bits.
  function automatic logic signed [ZW-1:0] scale_q24(input logic [31:0] v24);
    logic [31:0] r;
    r = (v24 + (32'd1 << (23 - ZFRAC))) >> (24 - ZFRAC);
    return $signed(ZW'(r));
  endfunction

  // round(atan(2^-i) * 2^24)
  function automatic logic [31:0] atan_q24(input logic [3:0] i);
    case (i)
      4'd0:    return 32'd13176795;
      4'd1:    return 32'd7778716;
      4'd2:    return 32'd4110060;
      4'd3:    return 32'd2086331;
      4'd4:    return 32'd1047214;
      4'd5:    return 32'd524117;
      4'd6:    return 32'd262123;
      4'd7:    return 32'd131069;
      4'd8:    return 32'd65536;
      4'd9:    return 32'd32768;
      4'd10:   return 32'd16384;
      4'd11:   return 32'd8192;
      4'd12:   return 32'd4096;
      4'd13:   return 32'd2048;
      4'd14:   return 32'd1024;
      default: return 32'd512;
    endcase
  endfunction

  localparam logic signed [ZW-1:0] HalfPi = scale_q24(32'd26353589);

  logic [2:0]           state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [3:0]           i_q, i_d;
  logic                 zf_q, zf_d;
  logic signed [26:0]   angle_q, angle_d;
  logic                 zero_q, zero_d;
  logic                 ov_q, ov_d;

  logic signed [XW-1:0] x_sh, y_sh;
  logic signed [ZW-1:0] tab;
  logic                 unused_zlsb;

  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;
  assign tab  = scale_q24(atan_q24(i_q));
  assign unused_zlsb = ^z_q[ZFRAC-10:0];

`ifdef ATAN2_CORDIC_MAG_EN
  localparam int unsigned MSH = 16 + GUARD;
  logic [26:0]    mag_q, mag_d;
  logic [XW+16:0] mag_prod, mag_rnd;
  logic           unused_mag;

  // x is non-negative after pre-rotation, so an unsigned product is exact.
  assign mag_prod = {17'd0, x_q} * {{XW{1'b0}}, 17'd39797};
  assign mag_rnd  = mag_prod + ({{(XW+16){1'b0}}, 1'b1} << (MSH - 1));
  assign unused_mag = ^{mag_rnd[XW+16:MSH+27], mag_rnd[MSH-1:0]};
  assign mag = mag_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = ov_q;
  assign angle     = angle_q;
  assign zero      = zero_q;

  // Next-state: capture, quadrant pre-rotation, micro-rotations, rounding.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zf_d    = zf_q;
    angle_d = angle_q;
    zero_d  = zero_q;
    ov_d    = ov_q;
`ifdef ATAN2_CORDIC_MAG_EN
    mag_d   = mag_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = $signed({{2{x_in[26]}}, x_in, {GUARD{1'b0}}});
          y_d     = $signed({{2{y_in[26]}}, y_in, {GUARD{1'b0}}});
          zf_d    = (x_in == 27'sd0) && (y_in == 27'sd0);
          state_d = StPrerot;
        end
      end
      StPrerot: begin
        // Fold the left half-plane into the right; y=0 goes to +pi.
        if (x_q[XW-1] && !y_q[XW-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = HalfPi;
        end else if (x_q[XW-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -HalfPi;
        end else begin
          z_d = '0;
        end
        i_d     = '0;
        state_d = StIter;
      end
      StIter: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + tab;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - tab;
        end
        i_d = i_q + 4'd1;
        if (i_q == 4'(ITERS - 1)) state_d = StRound;
      end
      StRound: begin
        angle_d = zf_q ? 27'sd0 : (z_q[ZFRAC+18 -: 27] + {26'd0, z_q[ZFRAC-9]});
        zero_d  = zf_q;
`ifdef ATAN2_CORDIC_MAG_EN
        mag_d   = zf_q ? 27'd0 : mag_rnd[MSH+26:MSH];
`endif
        ov_d    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; en=0 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zf_q    <= 1'b0;
      angle_q <= '0;
      zero_q  <= 1'b0;
      ov_q    <= 1'b0;
`ifdef ATAN2_CORDIC_MAG_EN
      mag_q   <= '0;
`endif
    end else if (en) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zf_q    <= zf_d;
      angle_q <= angle_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
`ifdef ATAN2_CORDIC_MAG_EN
      mag_q   <= mag_d;
`endif
    end
  end

endmodule

// File: tb/tb_atan2_cordic.sv
// Directed testbench for atan2_cordic: vector table plus handshake, stall
// and reset sequences.
module tb_atan2_cordic;

  logic               clk = 1'b0;
  logic               rst, en, in_valid, out_ready;
  logic               in_ready, out_valid, zero;
  logic signed [26:0] x_in, y_in, angle;
`ifdef ATAN2_CORDIC_MAG_EN
  logic        [26:0] mag;
`endif

  int total = 0;
  int bad   = 0;

  atan2_cordic dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .zero      (zero)
`ifdef ATAN2_CORDIC_MAG_EN
    ,
    .mag       (mag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int lo;
    int hi;
    int zf;
  } vec_t;

  vec_t vecs[13];

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Present (x, y), wait for accept, then count enabled-or-stalled edges to
  // out_valid. en is dropped for stall_len edges starting at edge stall_at.
  task automatic run_txn(input int x, input int y, input int stall_at, input int stall_len,
                         output int lat);
    int n;
    @(negedge clk);
    en       = 1'b1;
    x_in     = 27'(x);
    y_in     = 27'(y);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      en = !(lat >= stall_at && lat < stall_at + stall_len);
      @(posedge clk);
      #1;
      lat++;
    end
    en = 1'b1;
    check_range("out_valid_seen", int'(out_valid), 1, 1);
  endtask

  task automatic ack(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_range({name, "_ack_valid_low"}, int'(out_valid), 0, 0);
  endtask

  initial begin
    int lat;
    int a;

    vecs[0]  = '{256, 256, 200, 202, 0};
    vecs[1]  = '{-256, 0, 804, 805, 0};
    vecs[2]  = '{0, -256, -403, -401, 0};
    vecs[3]  = '{-256, -1, -805, -803, 0};
    vecs[4]  = '{0, 0, 0, 0, 1};
    vecs[5]  = '{256, 0, 0, 0, 0};
    vecs[6]  = '{-1000, 500, 685, 687, 0};
    vecs[7]  = '{1000, -500, -120, -118, 0};
    vecs[8]  = '{300, 400, 236, 238, 0};
    vecs[9]  = '{-300, 400, 566, 568, 0};
    vecs[10] = '{-67108864, 0, 804, 805, 0};
    vecs[11] = '{67108863, 67108863, 200, 202, 0};
    vecs[12] = '{-67108864, -67108864, -604, -602, 0};

    rst       = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    #12;
    check_range("rst_in_ready", int'(in_ready), 1, 1);
    check_range("rst_out_valid", int'(out_valid), 0, 0);
    check_range("rst_angle", int'(angle), 0, 0);
    check_range("rst_zero", int'(zero), 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 13; k++) begin
      run_txn(vecs[k].x, vecs[k].y, 1000, 0, lat);
      a = angle;
      check_range($sformatf("vec%0d_latency", k), lat, 14, 14);
      check_range($sformatf("vec%0d_angle", k), a, vecs[k].lo, vecs[k].hi);
      check_range($sformatf("vec%0d_zero", k), int'(zero), vecs[k].zf, vecs[k].zf);
      ack($sformatf("vec%0d", k));
    end

    // Backpressure: result held while new input is presented and ignored.
    run_txn(256, 256, 1000, 0, lat);
`ifdef ATAN2_CORDIC_MAG_EN
    check_range("mag_256_256", int'(mag), 361, 363);
`endif
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = -27'sd1000;
    y_in     = 27'sd500;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      a = angle;
      check_range("bp_out_valid", int'(out_valid), 1, 1);
      check_range("bp_in_ready", int'(in_ready), 0, 0);
      check_range("bp_angle", a, 200, 202);
      check_range("bp_zero", int'(zero), 0, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_range("bp_release_valid", int'(out_valid), 0, 0);
    check_range("bp_release_in_ready", int'(in_ready), 1, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_range("bp_second_accepted", int'(in_ready), 0, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    a = angle;
    check_range("bp_second_latency", lat, 14, 14);
    check_range("bp_second_angle", a, 685, 687);
    ack("bp_second");

    // Clock-enable stall of 3 cycles in the middle of the iterations.
    run_txn(300, 400, 4, 3, lat);
    a = angle;
    check_range("stall_latency", lat, 17, 17);
    check_range("stall_angle", a, 236, 238);
    ack("stall");

    // Reset at iteration 5 abandons the transaction.
    @(negedge clk);
    x_in     = 27'sd256;
    y_in     = 27'sd256;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    a = angle;
    check_range("midrst_out_valid", int'(out_valid), 0, 0);
    check_range("midrst_in_ready", int'(in_ready), 1, 1);
    check_range("midrst_angle", a, 0, 0);
    check_range("midrst_zero", int'(zero), 0, 0);
    @(negedge clk);
    rst = 1'b1;
    run_txn(-1000, 500, 1000, 0, lat);
    a = angle;
    check_range("postrst_latency", lat, 14, 14);
    check_range("postrst_angle", a, 685, 687);
    ack("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
